// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler
// Top-level sequencer for the convolution engine. Walks the output feature map
// tile by tile in row-major order (col inner, channel tile innermost). For each
// channel tile it pulses the load unit and then the MAC unit. After the last
// channel tile it pulses the store unit. Each pulse is followed by a wait for
// that unit's done.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start_i                run request, sampled in IDLE only
//   busy_o                 high whenever the scheduler is not idle
//   done_o                 one-cycle pulse at the end of a run
//   load_start_o           one-cycle pulse to the load unit
//   load_done_i            load unit completion
//   mac_start_o            one-cycle pulse to the MAC unit
//   acc_clear_o            with mac_start_o on the first channel tile
//   mac_done_i             MAC unit completion
//   store_start_o          one-cycle pulse to the store unit
//   store_done_i           store unit completion
//   row_idx_o, col_idx_o   current output tile position
//   ch_idx_o               current input-channel tile
module conv_tile_scheduler #(
   parameter int ROW_TILES = 4,
   parameter int COL_TILES = 4,
   parameter int CH_TILES  = 2,
   localparam int RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1,
   localparam int CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1,
   localparam int HW = (CH_TILES  > 1) ? $clog2(CH_TILES)  : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          load_start_o,
   input  logic          load_done_i,
   output logic          mac_start_o,
   output logic          acc_clear_o,
   input  logic          mac_done_i,
   output logic          store_start_o,
   input  logic          store_done_i,
   output logic [RW-1:0] row_idx_o,
   output logic [CW-1:0] col_idx_o,
   output logic [HW-1:0] ch_idx_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_LWAIT = 3'd2,
      S_MAC   = 3'd3,
      S_MWAIT = 3'd4,
      S_STORE = 3'd5,
      S_SWAIT = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   localparam logic [RW-1:0] ROW_LAST = RW'(ROW_TILES - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COL_TILES - 1);
   localparam logic [HW-1:0] CH_LAST  = HW'(CH_TILES - 1);

   state_t        state_r;
   logic          busy_r;
   logic          done_r;
   logic          load_start_r;
   logic          mac_start_r;
   logic          acc_clear_r;
   logic          store_start_r;
   logic [RW-1:0] row_r;
   logic [CW-1:0] col_r;
   logic [HW-1:0] ch_r;

   assign busy_o        = busy_r;
   assign done_o        = done_r;
   assign load_start_o  = load_start_r;
   assign mac_start_o   = mac_start_r;
   assign acc_clear_o   = acc_clear_r;
   assign store_start_o = store_start_r;
   assign row_idx_o     = row_r;
   assign col_idx_o     = col_r;
   assign ch_idx_o      = ch_r;

   // Scheduler FSM; every output is registered alongside the state it belongs to,
   // so each pulse is set on the transition into its issue state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_IDLE;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         load_start_r  <= 1'b0;
         mac_start_r   <= 1'b0;
         acc_clear_r   <= 1'b0;
         store_start_r <= 1'b0;
         row_r         <= '0;
         col_r         <= '0;
         ch_r          <= '0;
      end else begin
         // Pulses default low; busy defaults high and is dropped only when heading to IDLE.
         busy_r        <= 1'b1;
         done_r        <= 1'b0;
         load_start_r  <= 1'b0;
         mac_start_r   <= 1'b0;
         acc_clear_r   <= 1'b0;
         store_start_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               row_r <= '0;
               col_r <= '0;
               ch_r  <= '0;
               if (start_i) begin
                  state_r      <= S_LOAD;
                  load_start_r <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            S_LOAD: begin
               state_r <= S_LWAIT;
            end
            S_LWAIT: begin
               if (load_done_i) begin
                  state_r     <= S_MAC;
                  mac_start_r <= 1'b1;
                  acc_clear_r <= (ch_r == HW'(0));
               end else begin
                  state_r <= S_LWAIT;
               end
            end
            S_MAC: begin
               state_r <= S_MWAIT;
            end
            S_MWAIT: begin
               if (!mac_done_i) begin
                  state_r <= S_MWAIT;
               end else if (ch_r == CH_LAST) begin
                  state_r       <= S_STORE;
                  store_start_r <= 1'b1;
               end else begin
                  ch_r         <= ch_r + HW'(1);
                  state_r      <= S_LOAD;
                  load_start_r <= 1'b1;
               end
            end
            S_STORE: begin
               state_r <= S_SWAIT;
            end
            S_SWAIT: begin
               if (!store_done_i) begin
                  state_r <= S_SWAIT;
               end else begin
                  ch_r <= '0;
                  if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                  end else if (col_r == COL_LAST) begin
                     col_r        <= '0;
                     row_r        <= row_r + RW'(1);
                     state_r      <= S_LOAD;
                     load_start_r <= 1'b1;
                  end else begin
                     col_r        <= col_r + CW'(1);
                     state_r      <= S_LOAD;
                     load_start_r <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               row_r   <= '0;
               col_r   <= '0;
               ch_r    <= '0;
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               row_r   <= '0;
               col_r   <= '0;
               ch_r    <= '0;
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: a default-sized instance driven by
// a done-responder (tied-high, random-stall or fixed-delay) and a 1x1x1 instance.
// Observed pulse events are compared against a tile-walk model built with loops.
module tb_conv_tile_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_i, load_done_i, mac_done_i, store_done_i;
   logic       busy_o, done_o, load_start_o, mac_start_o, acc_clear_o, store_start_o;
   logic [1:0] row_idx_o, col_idx_o;
   logic [0:0] ch_idx_o;

   logic       start1, ld1, md1, sd1;
   logic       busy1, done1, load1, mac1, clr1, store1;
   logic [0:0] r1, c1, h1;

   conv_tile_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .load_start_o(load_start_o), .load_done_i(load_done_i),
      .mac_start_o(mac_start_o), .acc_clear_o(acc_clear_o), .mac_done_i(mac_done_i),
      .store_start_o(store_start_o), .store_done_i(store_done_i),
      .row_idx_o(row_idx_o), .col_idx_o(col_idx_o), .ch_idx_o(ch_idx_o));

   conv_tile_scheduler #(.ROW_TILES(1), .COL_TILES(1), .CH_TILES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
      .load_start_o(load1), .load_done_i(ld1),
      .mac_start_o(mac1), .acc_clear_o(clr1), .mac_done_i(md1),
      .store_start_o(store1), .store_done_i(sd1),
      .row_idx_o(r1), .col_idx_o(c1), .ch_idx_o(h1));

   typedef struct packed {
      logic [2:0] kind;   // 1 load, 2 mac, 3 store, 4 done
      logic [7:0] row;
      logic [7:0] col;
      logic [7:0] ch;
      logic       clr;
   } ev_t;

   ev_t  ev_q[$];
   ev_t  exp_q[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;
   int   t0     = 0;
   int   done_cyc = -1;
   int   proto_viol = 0;
   int   idx_viol   = 0;
   int   mode = 0;          // 0 dones tied high, 1 random stall + spurious, 2 fixed delay 3
   bit   mon_en = 1'b0;
   logic [2:0] pend = 3'b000;
   int   cnt [3];
   logic [4:0] last_idx = 5'd0;

   wire [10:0] outs = {busy_o, done_o, load_start_o, mac_start_o, acc_clear_o,
                       store_start_o, row_idx_o, col_idx_o, ch_idx_o};
   wire [8:0]  outs1 = {busy1, done1, load1, mac1, clr1, store1, r1, c1, h1};

   // Expected event list from the row-major tile walk.
   task automatic build_model(input int nr, input int nc, input int nh);
      ev_t e;
      exp_q.delete();
      for (int r = 0; r < nr; r++) begin
         for (int c = 0; c < nc; c++) begin
            for (int h = 0; h < nh; h++) begin
               e.kind = 3'd1; e.row = 8'(r); e.col = 8'(c); e.ch = 8'(h); e.clr = 1'b0;
               exp_q.push_back(e);
               e.kind = 3'd2; e.clr = (h == 0);
               exp_q.push_back(e);
            end
            e.kind = 3'd3; e.row = 8'(r); e.col = 8'(c); e.ch = 8'(nh - 1); e.clr = 1'b0;
            exp_q.push_back(e);
         end
      end
      e = '0; e.kind = 3'd4;
      exp_q.push_back(e);
   endtask

   function automatic int first_diff();
      int n;
      n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (ev_q[i] !== exp_q[i]) return i;
      if (ev_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   // One clock: record events at the falling edge, then update the done responder.
   task automatic step();
      logic [2:0] s;
      logic [2:0] d;
      ev_t e;
      @(negedge clk);
      cyc++;
      s = {store_start_o, mac_start_o, load_start_o};
      if (mon_en && rst_n) begin
         e.row = 8'(row_idx_o); e.col = 8'(col_idx_o); e.ch = 8'(ch_idx_o); e.clr = 1'b0;
         if (load_start_o) begin e.kind = 3'd1; ev_q.push_back(e); end
         if (mac_start_o) begin e.kind = 3'd2; e.clr = acc_clear_o; ev_q.push_back(e); end
         if (store_start_o) begin e.kind = 3'd3; e.clr = 1'b0; ev_q.push_back(e); end
         if (done_o) begin e = '0; e.kind = 3'd4; ev_q.push_back(e); done_cyc = cyc; end
         if (acc_clear_o && !mac_start_o) proto_viol++;
         if (s != 3'b000) last_idx = {row_idx_o, col_idx_o, ch_idx_o};
         else if (busy_o && !done_o && ({row_idx_o, col_idx_o, ch_idx_o} !== last_idx)) idx_viol++;
         if (!busy_o && ({row_idx_o, col_idx_o, ch_idx_o} !== 5'd0)) idx_viol++;
      end
      if (rst_n && mode != 0 && s != 3'b000 && pend != 3'b000) proto_viol++;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            pend[i] = 1'b0; d[i] = 1'b0;
         end else if (mode == 0) begin
            d[i] = 1'b1;
         end else if (pend[i]) begin
            if (cnt[i] == 0) begin d[i] = 1'b1; pend[i] = 1'b0; end
            else begin cnt[i]--; d[i] = 1'b0; end
         end else if (s[i]) begin
            pend[i] = 1'b1;
            cnt[i]  = (mode == 1) ? int'($urandom_range(0, 7)) : 3;
            d[i]    = (mode == 1) && ($urandom_range(0, 1) == 1);
         end else begin
            d[i] = (mode == 1) && ($urandom_range(0, 3) == 0);
         end
      end
      load_done_i  = d[0];
      mac_done_i   = d[1];
      store_done_i = d[2];
   endtask

   task automatic clear_mon();
      ev_q.delete(); done_cyc = -1; proto_viol = 0; idx_viol = 0; last_idx = 5'd0; mon_en = 1'b1;
   endtask

   task automatic launch();
      start_i = 1'b1; t0 = cyc; step(); start_i = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         step();
         if (done_cyc >= 0) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start_i = 1'b0; start1 = 1'b0;
      load_done_i = 1'b0; mac_done_i = 1'b0; store_done_i = 1'b0;
      ld1 = 1'b1; md1 = 1'b1; sd1 = 1'b1;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if ({outs, outs1} !== 20'd0) begin
            $display("FAIL reset_hold cyc%0d: got %h/%h, want 0/0", i, outs, outs1);
         end else passed++;
         start_i = 1'($urandom); start1 = 1'($urandom);
         load_done_i = 1'($urandom); mac_done_i = 1'($urandom); store_done_i = 1'($urandom);
      end
      start_i = 1'b0; start1 = 1'b0;
      rst_n = 1'b1;
      mode = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         total++;
         if ({outs, outs1} !== 20'd0) begin
            $display("FAIL idle_after_reset cyc%0d: got %h/%h, want 0/0", i, outs, outs1);
         end else passed++;
      end
   endtask

   task automatic test_back_to_back();
      bit seen;
      int nl, nm, ns, nc, fd;
      mode = 0; clear_mon(); build_model(4, 4, 2);
      launch();
      wait_done(400, seen);
      total++;
      if (!seen) $display("FAIL b2b_timeout: done_o seen=%0d, want 1", seen); else passed++;
      total++;
      if (done_cyc - t0 !== 161) $display("FAIL b2b_done_cycle: got %0d, want 161", done_cyc - t0);
      else passed++;
      nl = 0; nm = 0; ns = 0; nc = 0;
      foreach (ev_q[i]) begin
         if (ev_q[i].kind == 3'd1) nl++;
         if (ev_q[i].kind == 3'd2) nm++;
         if (ev_q[i].kind == 3'd3) ns++;
         if (ev_q[i].kind == 3'd2 && ev_q[i].clr) nc++;
      end
      total++; if (nl !== 32) $display("FAIL b2b_loads: got %0d, want 32", nl); else passed++;
      total++; if (nm !== 32) $display("FAIL b2b_macs: got %0d, want 32", nm); else passed++;
      total++; if (ns !== 16) $display("FAIL b2b_stores: got %0d, want 16", ns); else passed++;
      total++; if (nc !== 16) $display("FAIL b2b_acc_clear: got %0d, want 16", nc); else passed++;
      fd = first_diff();
      total++;
      if (fd !== -1) $display("FAIL b2b_sequence: first diff at %0d got %h want %h", fd,
                              (fd < ev_q.size()) ? ev_q[fd] : '0, (fd < exp_q.size()) ? exp_q[fd] : '0);
      else passed++;
      total++; if (idx_viol !== 0) $display("FAIL b2b_index_stable: got %0d, want 0", idx_viol); else passed++;
      step();
      total++;
      if ({busy_o, done_o} !== 2'b00) $display("FAIL b2b_busy_fall: got %b, want 00", {busy_o, done_o});
      else passed++;
   endtask

   task automatic test_random_stall();
      bit seen;
      int fd;
      for (int run = 0; run < 3; run++) begin
         mode = 1; clear_mon(); build_model(4, 4, 2);
         launch();
         wait_done(4000, seen);
         total++;
         if (!seen) $display("FAIL stall_timeout run%0d: seen=%0d, want 1", run, seen); else passed++;
         fd = first_diff();
         total++;
         if (fd !== -1) $display("FAIL stall_sequence run%0d: first diff at %0d got %h want %h", run, fd,
                                 (fd < ev_q.size()) ? ev_q[fd] : '0, (fd < exp_q.size()) ? exp_q[fd] : '0);
         else passed++;
         total++;
         if (proto_viol !== 0) $display("FAIL stall_protocol run%0d: got %0d, want 0", run, proto_viol);
         else passed++;
         total++;
         if (idx_viol !== 0) $display("FAIL stall_index_stable run%0d: got %0d, want 0", run, idx_viol);
         else passed++;
         repeat (3) step();
      end
   endtask

   task automatic test_single();
      logic [8:0] expv;
      mon_en = 1'b0;
      start1 = 1'b1; step(); start1 = 1'b0;
      for (int r = 1; r <= 9; r++) begin
         expv = {(r >= 1 && r <= 7), (r == 7), (r == 1), (r == 3), (r == 3), (r == 5), 3'b000};
         total++;
         if (outs1 !== expv) $display("FAIL single_cycle%0d: got %b, want %b", r, outs1, expv);
         else passed++;
         step();
      end
   endtask

   task automatic test_start_held();
      bit seen;
      int fd;
      mode = 0; clear_mon(); build_model(4, 4, 2);
      start_i = 1'b1; t0 = cyc;
      wait_done(400, seen);
      total++;
      if (done_cyc - t0 !== 161) $display("FAIL held_done_cycle: got %0d, want 161", done_cyc - t0);
      else passed++;
      fd = first_diff();
      total++;
      if (fd !== -1) $display("FAIL held_ignored: first diff at %0d got %h want %h", fd,
                              (fd < ev_q.size()) ? ev_q[fd] : '0, (fd < exp_q.size()) ? exp_q[fd] : '0);
      else passed++;
      step();
      total++;
      if ({busy_o, load_start_o} !== 2'b00) $display("FAIL held_idle_gap: got %b, want 00", {busy_o, load_start_o});
      else passed++;
      ev_q.delete(); done_cyc = -1;
      step();
      start_i = 1'b0;
      t0 = cyc - 1;
      total++;
      if ({busy_o, load_start_o} !== 2'b11) $display("FAIL held_restart: got %b, want 11", {busy_o, load_start_o});
      else passed++;
      wait_done(400, seen);
      total++;
      if (done_cyc - t0 !== 161) $display("FAIL held_run2_done: got %0d, want 161", done_cyc - t0);
      else passed++;
      fd = first_diff();
      total++;
      if (fd !== -1) $display("FAIL held_run2_sequence: first diff at %0d", fd); else passed++;
      repeat (2) step();
   endtask

   task automatic test_reset_midrun();
      bit seen, found;
      int fd;
      ev_t tgt;
      mode = 2; clear_mon();
      tgt = '0; tgt.kind = 3'd2; tgt.row = 8'd2; tgt.col = 8'd1; tgt.ch = 8'd1;
      launch();
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         step();
         if (ev_q.size() > 0 && ev_q[ev_q.size() - 1] === tgt) found = 1'b1;
      end
      total++;
      if (!found) $display("FAIL midrun_reach: found=%0d, want 1", found); else passed++;
      step();
      rst_n = 1'b0;
      #1;
      total++;
      if (outs !== 11'd0) $display("FAIL midrun_async_clear: got %h, want 0", outs); else passed++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (outs !== 11'd0) $display("FAIL midrun_held cyc%0d: got %h, want 0", i, outs); else passed++;
      end
      rst_n = 1'b1;
      step();
      total++;
      if (outs !== 11'd0) $display("FAIL midrun_release: got %h, want 0", outs); else passed++;
      clear_mon(); build_model(4, 4, 2);
      launch();
      wait_done(2000, seen);
      total++;
      if (ev_q.size() == 0 || ev_q[0] !== exp_q[0])
         $display("FAIL midrun_replay_first: got %h, want %h", (ev_q.size() > 0) ? ev_q[0] : '0, exp_q[0]);
      else passed++;
      fd = first_diff();
      total++;
      if (fd !== -1) $display("FAIL midrun_replay_sequence: first diff at %0d", fd); else passed++;
      repeat (2) step();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_random_stall();
      test_single();
      test_start_held();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
      $fatal(1);
   end

endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Top-level sequencer for the convolution engine. It walks the output feature map tile by tile. For each tile it accumulates over all input-channel tiles by driving start pulses to the load (weight/activation fill) unit and the MAC array unit, then drives the store (writeback) unit. Each sub-unit is a start/done counter-style block. The scheduler only issues pulses, waits for done, and publishes the current tile indices to the address generators.

## Interface
- ROW_TILES, 4: output tile rows per run (≥1)
- COL_TILES, 4: output tile columns per run (≥1)
- CH_TILES, 2: input-channel tiles accumulated per output tile (≥1)
- Index widths: RW = max(1, $clog2(ROW_TILES)), CW = max(1, $clog2(COL_TILES)), HW = max(1, $clog2(CH_TILES))

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  run request, sampled in IDLE only
- busy_o  out  1  high whenever state ≠ IDLE
- done_o  out  1  one-cycle pulse at end of run
- load_start_o  out  1  one-cycle pulse to load unit
- load_done_i  in  1  load unit completion
- mac_start_o  out  1  one-cycle pulse to MAC unit
- acc_clear_o  out  1  high with mac_start_o when ch_idx_o==0
- mac_done_i  in  1  MAC unit completion
- store_start_o  out  1  one-cycle pulse to store unit
- store_done_i  in  1  store unit completion
- row_idx_o  out  RW  current tile row
- col_idx_o  out  CW  current tile column
- ch_idx_o  out  HW  current channel tile

## Operation
- States: IDLE, LOAD, LWAIT, MAC, MWAIT, STORE, SWAIT, DONE. Encoding is free. Unused encodings go to IDLE.
- IDLE: row/col/ch = 0. On start_i → LOAD.
- LOAD: load_start_o=1 → LWAIT.
- LWAIT: on load_done_i → MAC. Otherwise hold.
- MAC: mac_start_o=1, acc_clear_o=(ch==0) → MWAIT.
- MWAIT: on mac_done_i:
  - if ch==CH_TILES-1 → STORE
  - else ch++ → LOAD
- STORE: store_start_o=1 → SWAIT.
- SWAIT: on store_done_i: ch←0, then:
  - if row==ROW_TILES-1 and col==COL_TILES-1 → DONE
  - else if col==COL_TILES-1: col←0, row++ → LOAD
  - else col++ → LOAD
- DONE: done_o=1, indices cleared to 0 → IDLE.
- Traversal order is row-major: col is the inner loop, ch the innermost.
- Indices change only on the transitions above. They are stable throughout every issue and wait state of a tile.
- Done inputs are honoured only in their own wait state. A done in any other state (including a done coincident with the start pulse) is ignored and not remembered.
- start_i outside IDLE is ignored. There is no abort; only rst_n stops a run.
- All outputs are registered or decoded from the state register. No combinational path from any input to any output.

## Timing
- Reset (async assert; synchronous deassert assumed at system level): state=IDLE, all outputs 0, indices 0. Reset mid-run drops all pulses immediately. No done_o is produced.
- start_i sampled high in IDLE at edge k: busy_o and load_start_o high in cycle k+1.
- Every start pulse is exactly one cycle wide.
- A wait state lasts ≥1 cycle. If done is high in the first wait cycle, the next issue state follows in the next cycle.
- With all done inputs tied high, the run takes ROW_TILES·COL_TILES·(4·CH_TILES+2) cycles. done_o is high in the following cycle. With defaults, done_o is in cycle 161 after the start sample.
- busy_o falls in the cycle after done_o. start_i is accepted again the same cycle busy_o is low.
- Parameters equal to 1 give a 1-bit index held at 0. CH_TILES=1 makes acc_clear_o high on every mac_start_o.

## Test plan
- Reset/idle: hold rst_n low, toggle start_i and all done inputs → all outputs 0. Release, no start → outputs stay 0.
- Back-to-back, defaults, done inputs tied high, start pulse → exactly 32 load, 32 mac, 16 store pulses. done_o in cycle 161. Index sequence (row,col) = (0,0),(0,1)…(3,3). acc_clear_o on 16 of the 32 mac pulses.
- Random stall: done inputs delayed 0–7 cycles, with spurious done in non-wait states → pulse counts and order unchanged; each start is followed by its matching done before the next issue.
- ROW=COL=CH=1: start → load, mac (with acc_clear), store, then done_o in cycle 7.
- start_i held high through the run plus a second start one cycle after done_o → start ignored while busy; second run starts load_start_o two cycles after done_o.
- Reset mid-run: assert rst_n low during MWAIT of tile (2,1), ch 1 → immediate return to IDLE with indices 0. A new start replays from (0,0,0).
